// File: rtl/hls_deadlock_token_ctrl_if.sv
// Signal bundle between the deadlock token sequencer, the per-process detection
// units and the simulation monitor. The master side is the sequencer.
interface hls_deadlock_token_ctrl_if #(
    parameter int PROC_NUM = 4,
    parameter int IDX_W    = 2
);
    logic [PROC_NUM-1:0] dl_detect_vec;
    logic [PROC_NUM-1:0] token_vec;
    logic                dl_detect_in;
    logic [PROC_NUM-1:0] origin_vec;
    logic [PROC_NUM-1:0] token_clear_vec;
    logic                report_vld;
    logic                report_ready;
    logic [PROC_NUM-1:0] report_proc_mask;
    logic [IDX_W-1:0]    report_origin;
    logic                report_timeout;
    logic                busy;

    modport master (
        input  dl_detect_vec, token_vec, report_ready,
        output dl_detect_in, origin_vec, token_clear_vec, report_vld,
               report_proc_mask, report_origin, report_timeout, busy
    );

    modport slave (
        output dl_detect_vec, token_vec, report_ready,
        input  dl_detect_in, origin_vec, token_clear_vec, report_vld,
               report_proc_mask, report_origin, report_timeout, busy
    );
endinterface

// File: rtl/hls_deadlock_token_ctrl.sv
// Deadlock sequencer: picks an origin process, launches the report token, tracks
// the processes it visits and hands one cycle report to the monitor.
module hls_deadlock_token_ctrl #(
    parameter int PROC_NUM = 4,
    parameter int IDX_W    = 2,
    parameter int CNT_W    = 8,
    parameter int TIMEOUT  = 255
) (
    input  logic                       clock_i,
    input  logic                       reset_ni,
    hls_deadlock_token_ctrl_if.master  ctrl
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ARM    = 2'd1;
    localparam logic [1:0] S_WALK   = 2'd2;
    localparam logic [1:0] S_REPORT = 2'd3;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    logic [1:0]          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PROC_NUM-1:0] mask_q, mask_d;
    logic [IDX_W-1:0]    origin_q, origin_d;
    logic                timeout_q, timeout_d;
    logic [PROC_NUM-1:0] origin_vec_q, origin_vec_d;

    logic [IDX_W-1:0]    low_idx;
    logic [PROC_NUM-1:0] origin_oh;
    logic [PROC_NUM-1:0] token_clear;
    logic                token_back;

    // Descending scan so the lowest requesting index is the one left standing.
    always_comb begin
        low_idx = '0;
        for (int i = PROC_NUM - 1; i >= 0; i--) begin
            if (ctrl.dl_detect_vec[i]) begin
                low_idx = IDX_W'(i);
            end
        end
    end

    assign origin_oh  = PROC_NUM'(1) << origin_q;
    // The origin holds the token on the first walk cycle; that is the launch.
    assign token_back = ctrl.token_vec[origin_q] && (cnt_q != '0);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        mask_d       = mask_q;
        origin_d     = origin_q;
        timeout_d    = timeout_q;
        origin_vec_d = '0;
        token_clear  = '0;
        case (state_q)
            S_IDLE: begin
                if (|ctrl.dl_detect_vec) begin
                    origin_d     = low_idx;
                    mask_d       = PROC_NUM'(1) << low_idx;
                    origin_vec_d = PROC_NUM'(1) << low_idx;
                    state_d      = S_ARM;
                end
            end
            S_ARM: begin
                cnt_d   = '0;
                state_d = S_WALK;
            end
            S_WALK: begin
                mask_d = mask_q | ctrl.token_vec;
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (token_back) begin
                    token_clear = origin_oh;
                    timeout_d   = 1'b0;
                    state_d     = S_REPORT;
                end else if (cnt_q == CNT_MAX) begin
                    token_clear = '1;
                    timeout_d   = 1'b1;
                    state_d     = S_REPORT;
                end
            end
            S_REPORT: begin
                if (ctrl.report_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            mask_q       <= '0;
            origin_q     <= '0;
            timeout_q    <= 1'b0;
            origin_vec_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mask_q       <= mask_d;
            origin_q     <= origin_d;
            timeout_q    <= timeout_d;
            origin_vec_q <= origin_vec_d;
        end
    end

    // Report fields read as zero outside REPORT so the walk-in-progress mask never leaks.
    assign ctrl.busy             = (state_q != S_IDLE);
    assign ctrl.dl_detect_in     = (state_q != S_IDLE);
    assign ctrl.report_vld       = (state_q == S_REPORT);
    assign ctrl.report_proc_mask = (state_q == S_REPORT) ? mask_q : '0;
    assign ctrl.report_origin    = (state_q == S_REPORT) ? origin_q : '0;
    assign ctrl.report_timeout   = (state_q == S_REPORT) && timeout_q;
    assign ctrl.origin_vec       = origin_vec_q;
    assign ctrl.token_clear_vec  = token_clear;
endmodule

// File: tb/tb_hls_deadlock_token_ctrl.sv
// Randomized bench for hls_deadlock_token_ctrl: each walk's outcome is predicted
// from the token sequence with a transaction-level reference model.
module tb_hls_deadlock_token_ctrl;
    localparam int PROC_NUM = 4;
    localparam int IDX_W    = 2;
    localparam int CNT_W    = 8;
    localparam int TIMEOUT  = 8;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;
    logic [PROC_NUM-1:0] tok [0:TIMEOUT];

    hls_deadlock_token_ctrl_if #(.PROC_NUM(PROC_NUM), .IDX_W(IDX_W)) bus ();

    hls_deadlock_token_ctrl #(
        .PROC_NUM(PROC_NUM), .IDX_W(IDX_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clock_i (clk),
        .reset_ni(rst_n),
        .ctrl    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 32'(bus.busy), 0);
        chk({tag, "_dl_in"}, 32'(bus.dl_detect_in), 0);
        chk({tag, "_origin_vec"}, 32'(bus.origin_vec), 0);
        chk({tag, "_clear"}, 32'(bus.token_clear_vec), 0);
        chk({tag, "_vld"}, 32'(bus.report_vld), 0);
        chk({tag, "_mask"}, 32'(bus.report_proc_mask), 0);
        chk({tag, "_origin"}, 32'(bus.report_origin), 0);
        chk({tag, "_timeout"}, 32'(bus.report_timeout), 0);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            chk("idle_busy", 32'(bus.busy), 0);
            chk("idle_vld", 32'(bus.report_vld), 0);
        end
    endtask

    // Reference: origin is the lowest request bit; the walk ends at the first
    // non-launch cycle holding the token at the origin, else at cycle TIMEOUT.
    task automatic run_walk(input logic [PROC_NUM-1:0] req, input int stall);
        int o, e;
        logic to;
        logic [PROC_NUM-1:0] m, oh, exp_clr;
        o = 0;
        for (int i = PROC_NUM - 1; i >= 0; i--) if (req[i]) o = i;
        oh = PROC_NUM'(1) << o;
        m  = oh;
        e  = TIMEOUT;
        to = 1'b1;
        for (int k = 0; k <= TIMEOUT; k++) begin
            m = m | tok[k];
            if (k > 0 && tok[k][o]) begin
                e  = k;
                to = 1'b0;
                break;
            end
        end

        bus.dl_detect_vec = req;
        @(posedge clk); #1;
        chk("arm_origin_vec", 32'(bus.origin_vec), 32'(oh));
        chk("arm_dl_in", 32'(bus.dl_detect_in), 1);
        chk("arm_clear", 32'(bus.token_clear_vec), 0);
        bus.dl_detect_vec = PROC_NUM'($urandom);
        @(posedge clk); #1;

        for (int k = 0; k <= e; k++) begin
            bus.token_vec = tok[k];
            #1;
            exp_clr = (k == e) ? (to ? '1 : oh) : '0;
            chk("walk_clear", 32'(bus.token_clear_vec), 32'(exp_clr));
            chk("walk_origin_vec", 32'(bus.origin_vec), 0);
            chk("walk_dl_in", 32'(bus.dl_detect_in), 1);
            chk("walk_vld", 32'(bus.report_vld), 0);
            bus.dl_detect_vec = PROC_NUM'($urandom);
            @(posedge clk); #1;
        end

        for (int s = 0; s <= stall; s++) begin
            bus.token_vec = PROC_NUM'($urandom);
            #1;
            chk("rep_vld", 32'(bus.report_vld), 1);
            chk("rep_mask", 32'(bus.report_proc_mask), 32'(m));
            chk("rep_origin", 32'(bus.report_origin), 32'(o));
            chk("rep_timeout", 32'(bus.report_timeout), 32'(to));
            chk("rep_dl_in", 32'(bus.dl_detect_in), 1);
            chk("rep_clear", 32'(bus.token_clear_vec), 0);
            if (s < stall) begin
                @(posedge clk); #1;
            end
        end
        bus.report_ready = 1'b1;
        @(posedge clk); #1;
        bus.report_ready = 1'b0;
        chk("done_busy", 32'(bus.busy), 0);
        chk("done_dl_in", 32'(bus.dl_detect_in), 0);
        chk("done_vld", 32'(bus.report_vld), 0);
        bus.dl_detect_vec = '0;
        bus.token_vec     = '0;
    endtask

    // Random token sequence; mode 0 returns at a random cycle, 1 never returns,
    // 2 returns exactly on the timeout cycle.
    task automatic gen_tokens(input int o, input int mode);
        int r;
        logic [PROC_NUM-1:0] oh;
        oh = PROC_NUM'(1) << o;
        r  = (mode == 0) ? $urandom_range(1, TIMEOUT) : (mode == 2) ? TIMEOUT : TIMEOUT + 1;
        tok[0] = PROC_NUM'($urandom) | oh;
        for (int k = 1; k <= TIMEOUT; k++) begin
            tok[k] = PROC_NUM'($urandom) & ~oh;
            if (k == r) tok[k] = tok[k] | oh;
        end
    endtask

    initial begin
        logic [PROC_NUM-1:0] req;
        int o;
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b1;
        bus.dl_detect_vec = '0;
        bus.token_vec     = '0;
        bus.report_ready  = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        chk_all_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle_cycles(20);

        // Directed single ring: origin 2, token visits 3 and 0 before returning.
        for (int k = 0; k <= TIMEOUT; k++) tok[k] = '0;
        tok[0] = 4'b0100;
        tok[1] = 4'b1000;
        tok[2] = 4'b0001;
        tok[3] = 4'b0100;
        run_walk(4'b0100, 0);

        // Simultaneous requests resolve to index 1.
        gen_tokens(1, 0);
        run_walk(4'b1010, 2);

        // Pure timeout, then return coinciding with timeout, then long backpressure.
        gen_tokens(3, 1);
        run_walk(4'b1000, 1);
        gen_tokens(0, 2);
        run_walk(4'b0001, 0);
        gen_tokens(2, 0);
        run_walk(4'b1100, 10);

        for (int t = 0; t < 40; t++) begin
            req = PROC_NUM'($urandom_range(1, (1 << PROC_NUM) - 1));
            o = 0;
            for (int i = PROC_NUM - 1; i >= 0; i--) if (req[i]) o = i;
            gen_tokens(o, $urandom_range(0, 2));
            run_walk(req, $urandom_range(0, 4));
            idle_cycles($urandom_range(0, 2));
        end

        // Reset in the middle of a walk aborts without a report.
        bus.dl_detect_vec = 4'b0001;
        @(posedge clk); #1;
        bus.dl_detect_vec = '0;
        @(posedge clk); #1;
        bus.token_vec = 4'b0011;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk_all_zero("midwalk_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.token_vec = '0;
        idle_cycles(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
